ysyx_23060201_lsu: RTL and testbench



---
 rtl/ysyx_23060201_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu -- sequential load/store unit between EXU and the
// physical-memory model (pmem_read / pmem_write).
//
// One request is accepted per valid/ready handshake. Legal requests wait
// LATENCY cycles, perform exactly one memory access, then present the
// result. Misaligned or illegal-size requests skip the wait and the access
// and respond immediately with resp_err=1.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. Ready never depends on valid. The producer
// holds its payload stable while valid=1 and ready=0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request channel from EXU
//   req_wen               1 = store, 0 = load
//   req_size              RV funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid/resp_ready response channel to WBU
//   resp_rdata            extended load data, 0 for stores and errors
//   resp_err              misaligned access or illegal size
//   busy                  FSM is not idle
// ---------------------------------------------------------------------------

// Stand-alone SystemVerilog model of the memory behind the pmem calls, with
// the same call signatures. Counters and last-call arguments make each
// access observable from outside.
package ysyx_23060201_pmem_pkg;
  logic [31:0] mem [int];
  int unsigned read_calls  = 0;
  int unsigned write_calls = 0;
  int          last_raddr  = 0;
  int          last_waddr  = 0;
  int          last_wdata  = 0;
  byte         last_wmask  = 0;

  function automatic int pmem_read(input int raddr);
    read_calls = read_calls + 1;
    last_raddr = raddr;
    if (mem.exists(raddr)) return mem[raddr];
    return 0;
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
    logic [31:0] w;
    w = mem.exists(waddr) ? mem[waddr] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
    end
    mem[waddr]  = w;
    write_calls = write_calls + 1;
    last_waddr  = waddr;
    last_wdata  = wdata;
    last_wmask  = wmask;
  endfunction
endpackage

import ysyx_23060201_pmem_pkg::*;

module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  // Elaboration-time parameter checks.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ysyx_23060201_lsu: LATENCY must be within 1..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("ysyx_23060201_lsu: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [2:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  size_illegal;
  logic                  misaligned;
  logic                  access_now;
  logic [31:0]           addr_lo;
  logic [31:0]           word_addr;
  logic [31:0]           store_data;
  logic [3:0]            store_mask;

  // Request classification, evaluated on the live request in IDLE.
  always_comb begin
    size_illegal = 1'b0;
    misaligned   = 1'b0;
    case (req_size)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = req_addr[0];
      3'b010:         misaligned = (req_addr[1:0] != 2'b00);
      default:        size_illegal = 1'b1;
    endcase
  end

  // Next-state and latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'd0;
          rdata_d = '0;
          err_d   = size_illegal | misaligned;
          state_d = (size_illegal | misaligned) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory access datapath: word-aligned address, lane-shifted data and mask.
  always_comb begin
    addr_lo    = 32'(addr_q);
    word_addr  = {addr_lo[31:2], 2'b00};
    store_data = wdata_q << {addr_q[1:0], 3'b000};
    case (size_q[1:0])
      2'b00:   store_mask = 4'b0001 << addr_q[1:0];
      2'b01:   store_mask = 4'b0011 << addr_q[1:0];
      default: store_mask = 4'b1111;
    endcase
  end

  assign access_now = (state_q == S_WAIT) && (cnt_q == LAT_LAST);

  // Select the addressed lane, then sign- or zero-extend by funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      3'b000:  load_extend = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_extend = {24'h0, lane[7:0]};
      3'b001:  load_extend = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_extend = {16'h0, lane[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // State register. The single memory call per legal request lives here so
  // it fires exactly on the access edge and never under reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (access_now) begin
        if (wen_q) begin
          pmem_write(int'(word_addr), int'(store_data), byte'({4'b0000, store_mask}));
          rdata_q <= '0;
        end else begin
          rdata_q <= load_extend(pmem_read(int'(word_addr)), size_q, addr_q[1:0]);
        end
      end else begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060201_lsu. Two instances: dut1 (LATENCY=1) carries
// the directed and randomized traffic, dut4 (LATENCY=4) covers response
// back-pressure and reset during WAIT. Expected results come from a
// byte-addressed reference memory and the funct3 rules.
// ---------------------------------------------------------------------------
module tb_ysyx_23060201_lsu;
  import ysyx_23060201_pmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        rst4 = 1'b1;
  logic        req_valid4 = 1'b0, req_wen4 = 1'b0, resp_ready4 = 1'b0;
  logic [2:0]  req_size4 = 3'b000;
  logic [31:0] req_addr4 = 32'h0, req_wdata4 = 32'h0;
  logic        req_ready4, resp_valid4, resp_err4, busy4;
  logic [31:0] resp_rdata4;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_wen(req_wen4),
    .req_size(req_size4), .req_addr(req_addr4), .req_wdata(req_wdata4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_rdata(resp_rdata4), .resp_err(resp_err4), .busy(busy4)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] size);
    int n;
    longint unsigned v;
    n = size_bytes(size);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_byte(addr + 32'(i))) << (8 * i));
    if (!size[2] && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    for (int i = 0; i < size_bytes(size); i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  // ---------------- driver: one complete request on dut1 ----------------
  task automatic run_req1(input logic wen, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int n, cycles;
    logic legal;
    logic [31:0] exp_rdata, exp_wdata;
    logic [7:0]  exp_mask;
    int unsigned rc0, wc0;
    n     = size_bytes(size);
    legal = (n != 0) && (addr % n == 0);
    exp_rdata = (legal && !wen) ? model_load(addr, size) : 32'h0;
    exp_wdata = wdata << (8 * (addr % 4));
    exp_mask  = 8'h00;
    for (int i = 0; i < n; i++) exp_mask[(addr % 4) + i] = 1'b1;
    rc0 = read_calls;
    wc0 = write_calls;

    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;   // payload ignored outside IDLE
    cycles = 1;
    while (!resp_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("resp_latency", 32'(cycles), legal ? 32'd2 : 32'd1);
    check("resp_err", 32'(resp_err), legal ? 32'd0 : 32'd1);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("write_calls", 32'(write_calls - wc0), (legal && wen) ? 32'd1 : 32'd0);
    check("read_calls", 32'(read_calls - rc0), (legal && !wen) ? 32'd1 : 32'd0);
    if (legal && wen) begin
      check("pmem_waddr", 32'(last_waddr), addr & ~32'h3);
      check("pmem_wdata", 32'(last_wdata), exp_wdata);
      check("pmem_wmask", 32'(last_wmask), 32'(exp_mask));
      model_store(addr, size, wdata);
    end
    if (legal && !wen) check("pmem_raddr", 32'(last_raddr), addr & ~32'h3);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done_valid", 32'(resp_valid), 32'd0);
    check("resp_done_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cycles;
    int unsigned rc0, wc0;
    logic [31:0] exp4;
    logic [2:0]  sz;

    // Reset with a request pending on dut1: no memory call may occur.
    req_valid = 1'b1; req_wen = 1'b1; req_size = 3'b010;
    req_addr = 32'h80000000; req_wdata = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_no_calls", 32'(read_calls + write_calls), 32'd0);

    // Directed traffic.
    run_req1(1'b1, 3'b010, 32'h80000010, 32'hDEADBEEF);  // sw
    run_req1(1'b1, 3'b000, 32'h80000013, 32'h000000AB);  // sb
    run_req1(1'b0, 3'b100, 32'h80000013, 32'h0);         // lbu
    run_req1(1'b0, 3'b000, 32'h80000013, 32'h0);         // lb
    run_req1(1'b1, 3'b001, 32'h80000012, 32'h00008001);  // sh
    run_req1(1'b0, 3'b101, 32'h80000012, 32'h0);         // lhu
    run_req1(1'b0, 3'b001, 32'h80000012, 32'h0);         // lh
    run_req1(1'b0, 3'b010, 32'h80000010, 32'h0);         // lw
    run_req1(1'b0, 3'b010, 32'h80000002, 32'h0);         // misaligned lw
    run_req1(1'b1, 3'b011, 32'h80000010, 32'h55AA55AA);  // illegal size
    run_req1(1'b1, 3'b001, 32'h80000011, 32'h0000FFFF);  // misaligned sh
    check("lw_constant", model_load(32'h80000010, 3'b010), 32'h8001BEEF);

    // Randomized traffic in a small window so loads hit earlier stores.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: sz = 3'b000;
        1: sz = 3'b001;
        2: sz = 3'b100;
        3: sz = 3'b101;
        4: sz = 3'($urandom_range(6, 7));
        5: sz = 3'b011;
        default: sz = 3'b010;
      endcase
      run_req1(1'($urandom_range(0, 1)), sz,
               32'h80000100 + 32'($urandom_range(0, 31)), $urandom);
    end

    // LATENCY=4 instance: back-pressure on the response.
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    exp4 = model_load(32'h80000010, 3'b010);
    rc0 = read_calls;
    wc0 = write_calls;
    req_valid4 = 1'b1; req_wen4 = 1'b0; req_size4 = 3'b010; req_addr4 = 32'h80000010;
    check("l4_req_ready", 32'(req_ready4), 32'd1);
    @(negedge clk);
    req_valid4 = 1'b0;
    cycles = 1;
    while (!resp_valid4 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("l4_latency", 32'(cycles), 32'd5);
    check("l4_rdata", resp_rdata4, exp4);
    check("l4_read_calls", 32'(read_calls - rc0), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("l4_hold_valid", 32'(resp_valid4), 32'd1);
      check("l4_hold_rdata", resp_rdata4, exp4);
      check("l4_hold_err", 32'(resp_err4), 32'd0);
    end
    check("l4_single_read", 32'(read_calls - rc0), 32'd1);
    resp_ready4 = 1'b1;
    @(negedge clk);
    resp_ready4 = 1'b0;
    check("l4_idle_busy", 32'(busy4), 32'd0);
    check("l4_idle_ready", 32'(req_ready4), 32'd1);

    // Second request aborted by reset during WAIT.
    rc0 = read_calls;
    wc0 = write_calls;
    req_valid4 = 1'b1; req_wen4 = 1'b1; req_size4 = 3'b010;
    req_addr4 = 32'h80000014; req_wdata4 = 32'hCAFEF00D;
    @(negedge clk);
    req_valid4 = 1'b0;
    check("l4_wait_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("l4_abort_busy", 32'(busy4), 32'd0);
    check("l4_abort_ready", 32'(req_ready4), 32'd1);
    check("l4_abort_valid", 32'(resp_valid4), 32'd0);
    repeat (8) @(negedge clk);
    check("l4_abort_no_write", 32'(write_calls - wc0), 32'd0);
    check("l4_abort_no_read", 32'(read_calls - rc0), 32'd0);
    check("l4_abort_stays_idle", 32'(resp_valid4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
